// File: rtl/ex_mem.sv
// EX/MEM pipeline register for the five-stage MIPS core. It applies stall, bubble and flush,
// and carries the madd/msub partial product and cycle count across EX stalls.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
  } stage_t;

  stage_t ex_p, mem_p;

  assign ex_p = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                  hi: ex_hi, lo: ex_lo, aluop: ex_aluop, mem_addr: ex_mem_addr,
                  reg2: ex_reg2};

  logic ex_stall, mem_stall;
  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_p  <= '0;
      hilo_o <= '0;
      cnt_o  <= '0;
    end else if (ex_stall && !mem_stall) begin
      // Bubble: MEM sees a NOP while EX keeps its multi-cycle madd/msub progress.
      mem_p  <= '0;
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else if (!ex_stall) begin
      mem_p  <= ex_p;
      hilo_o <= '0;
      cnt_o  <= '0;
    end
  end

  assign mem_wd       = mem_p.wd;
  assign mem_wreg     = mem_p.wreg;
  assign mem_wdata    = mem_p.wdata;
  assign mem_whilo    = mem_p.whilo;
  assign mem_hi       = mem_p.hi;
  assign mem_lo       = mem_p.lo;
  assign mem_aluop    = mem_p.aluop;
  assign mem_mem_addr = mem_p.mem_addr;
  assign mem_reg2     = mem_p.reg2;

endmodule
